// File: rtl/rx_escape_pkg.sv
// Purpose: shared types and constants for the escape-sequence receive decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: decoder state enum, default escape symbol.
package rx_escape_pkg;

   typedef enum logic {
      ST_DATA   = 1'b0,   // normal symbols pass straight through
      ST_ESCAPE = 1'b1    // one ESC consumed, next symbol decides meaning
   } state_t;

   localparam logic [7:0] ESC_DEFAULT = 8'hB1;

endpackage

// File: rtl/rx_escape_fifo.sv
// Purpose: small show-ahead FIFO holding decoded {command, symbol} entries.
// Latency: a write is visible on rd_vld/rd_dat the cycle after the write edge.
// Backpressure: wr_rdy drops when full (writes ignored); rd_rdy ignored while empty.
// Ports: CLK_I/RST_NI clock and synchronous active-low reset; wr_vld/wr_dat/wr_rdy
//        write side; rd_rdy/rd_vld/rd_dat read side (rd_dat is 0 when empty);
//        level current occupancy.
module rx_escape_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                       CLK_I,
   input  logic                       RST_NI,
   input  logic                       wr_vld,
   input  logic [WIDTH-1:0]           wr_dat,
   output logic                       wr_rdy,
   input  logic                       rd_rdy,
   output logic                       rd_vld,
   output logic [WIDTH-1:0]           rd_dat,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   assign wr_rdy = (count != LW'(DEPTH));
   assign rd_vld = (count != '0);
   assign do_wr  = wr_vld && wr_rdy;
   assign do_rd  = rd_rdy && rd_vld;
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
   assign level  = count;

   // Storage has no reset: stale contents are never exposed because rd_dat
   // is masked while empty.
   always_ff @(posedge CLK_I) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_wr && !do_rd) begin
            count <= count + LW'(1);
         end else if (!do_wr && do_rd) begin
            count <= count - LW'(1);
         end
      end
   end

endmodule

// File: rtl/rx_unescape.sv
// Purpose: strips ESC framing from a UART-RX symbol stream and tags commands.
// Latency: one cycle from upstream pop to the decoded entry at the TAP side.
// Backpressure: upstream is popped only while the output FIFO has room.
// Ports: CLK_I/RST_NI clock and synchronous active-low reset; DATA_REC_I,
//        RX_EMPTY_I, READ_O upstream UART-RX side; READ_I, RX_EMPTY_O,
//        COMMAND_O, DATA_REC_O, LEVEL_O downstream TAP side; ESC_TIMEOUT_O
//        pulses when an unanswered ESC is discarded.
module rx_unescape
   import rx_escape_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] ESC     = DATA_W'(ESC_DEFAULT),
   parameter int                DEPTH   = 4,
   parameter int                TIMEOUT = 0
) (
   input  logic                       CLK_I,
   input  logic                       RST_NI,
   input  logic [DATA_W-1:0]          DATA_REC_I,
   input  logic                       RX_EMPTY_I,
   output logic                       READ_O,
   input  logic                       READ_I,
   output logic                       RX_EMPTY_O,
   output logic                       COMMAND_O,
   output logic [DATA_W-1:0]          DATA_REC_O,
   output logic [$clog2(DEPTH+1)-1:0] LEVEL_O,
   output logic                       ESC_TIMEOUT_O
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

   state_t          state;
   logic [CW-1:0]   esc_cnt;
   logic            to_pls;
   logic            pop_up;
   logic            is_esc;
   logic            cnt_hit;
   logic            wr_vld;
   logic [DATA_W:0] wr_dat;
   logic            fifo_rdy;
   logic            fifo_vld;
   logic [DATA_W:0] fifo_dat;
   logic [LW-1:0]   fifo_level;

   // Fullness alone gates the pop: a same-cycle TAP read does not make room.
   assign pop_up  = RST_NI && !RX_EMPTY_I && fifo_rdy;
   assign is_esc  = (DATA_REC_I == ESC);
   // True on the idle cycle whose edge brings the count up to TIMEOUT.
   assign cnt_hit = (TIMEOUT > 0) && (esc_cnt == CW'(TIMEOUT - 1));

   // Entry format is {command, symbol}. An escaped ESC is literal data.
   always_comb begin
      wr_vld = 1'b0;
      wr_dat = '0;
      if (pop_up) begin
         if (state == ST_ESCAPE) begin
            wr_vld = 1'b1;
            wr_dat = {!is_esc, DATA_REC_I};
         end else if (!is_esc) begin
            wr_vld = 1'b1;
            wr_dat = {1'b0, DATA_REC_I};
         end
      end
   end

   // A symbol read in the same cycle as the timeout takes priority.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         state   <= ST_DATA;
         esc_cnt <= '0;
         to_pls  <= 1'b0;
      end else begin
         to_pls <= 1'b0;
         case (state)
            ST_DATA: begin
               if (pop_up && is_esc) begin
                  state   <= ST_ESCAPE;
                  esc_cnt <= '0;
               end
            end
            ST_ESCAPE: begin
               if (pop_up) begin
                  state <= ST_DATA;
               end else if (cnt_hit) begin
                  state  <= ST_DATA;
                  to_pls <= 1'b1;
               end else if (TIMEOUT > 0) begin
                  esc_cnt <= esc_cnt + CW'(1);
               end
            end
            default: state <= ST_DATA;
         endcase
      end
   end

   rx_escape_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK_I  (CLK_I),
      .RST_NI (RST_NI),
      .wr_vld (wr_vld),
      .wr_dat (wr_dat),
      .wr_rdy (fifo_rdy),
      .rd_rdy (READ_I),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .level  (fifo_level)
   );

   // Outputs are forced to their idle values while reset is held, even
   // before the first reset edge has cleared the registers.
   assign READ_O        = pop_up;
   assign RX_EMPTY_O    = !(RST_NI && fifo_vld);
   assign COMMAND_O     = RST_NI && fifo_dat[DATA_W];
   assign DATA_REC_O    = RST_NI ? fifo_dat[DATA_W-1:0] : '0;
   assign LEVEL_O       = RST_NI ? fifo_level : '0;
   assign ESC_TIMEOUT_O = RST_NI && to_pls;

endmodule

// File: tb/tb_rx_unescape.sv
// Purpose: self-checking bench for rx_unescape with a queue-based decoder model.
// Latency: model expects entries one cycle after the upstream pop.
// Backpressure: model pops upstream only while its queue holds fewer than DEPTH.
module tb_rx_unescape;

   localparam int         DEPTH   = 4;
   localparam int         TIMEOUT = 10;
   localparam logic [7:0] ESC     = 8'hB1;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic [7:0] data_i     = 8'h00;
   logic       rx_empty_i = 1'b1;
   logic       read_i     = 1'b0;
   logic       read_o, rx_empty_o, command_o, esc_timeout_o;
   logic [7:0] data_o;
   logic [2:0] level_o;

   // Second instance with TIMEOUT=0 for the never-expire case.
   logic [7:0] data0_i     = 8'h00;
   logic       rx_empty0_i = 1'b1;
   logic       read0_o, rx_empty0_o, command0_o, esc_timeout0_o;
   logic [7:0] data0_o;
   logic [2:0] level0_o;

   int checks = 0;
   int errors = 0;

   rx_unescape #(.DATA_W(8), .ESC(ESC), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
      .CLK_I(clk), .RST_NI(rst_n), .DATA_REC_I(data_i), .RX_EMPTY_I(rx_empty_i),
      .READ_O(read_o), .READ_I(read_i), .RX_EMPTY_O(rx_empty_o),
      .COMMAND_O(command_o), .DATA_REC_O(data_o), .LEVEL_O(level_o),
      .ESC_TIMEOUT_O(esc_timeout_o)
   );

   rx_unescape #(.DATA_W(8), .ESC(ESC), .DEPTH(DEPTH), .TIMEOUT(0)) u_dut0 (
      .CLK_I(clk), .RST_NI(rst_n), .DATA_REC_I(data0_i), .RX_EMPTY_I(rx_empty0_i),
      .READ_O(read0_o), .READ_I(1'b0), .RX_EMPTY_O(rx_empty0_o),
      .COMMAND_O(command0_o), .DATA_REC_O(data0_o), .LEVEL_O(level0_o),
      .ESC_TIMEOUT_O(esc_timeout0_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Queue of {cmd, symbol}; pending ESC flag; idle cycles since the ESC.
   logic [8:0] mq[$];
   bit         m_pend = 0;
   int         m_idle = 0;
   bit         m_to   = 0;

   always @(negedge clk) begin : model
      bit up;
      bit tap;
      up = rst_n && !rx_empty_i && (mq.size() < DEPTH);
      chk("read_o",        32'(read_o),        32'(up));
      chk("rx_empty_o",    32'(rx_empty_o),    32'(!rst_n || mq.size() == 0));
      chk("data_o",        32'(data_o),        (rst_n && mq.size() > 0) ? 32'(mq[0][7:0]) : 32'd0);
      chk("command_o",     32'(command_o),     (rst_n && mq.size() > 0) ? 32'(mq[0][8]) : 32'd0);
      chk("level_o",       32'(level_o),       rst_n ? 32'(mq.size()) : 32'd0);
      chk("esc_timeout_o", 32'(esc_timeout_o), 32'(rst_n && m_to));
      if (!rst_n) begin
         mq.delete();
         m_pend = 0;
         m_idle = 0;
         m_to   = 0;
      end else begin
         tap  = read_i && (mq.size() > 0);
         m_to = 0;
         if (tap) void'(mq.pop_front());
         if (up) begin
            if (m_pend) begin
               mq.push_back({data_i != ESC, data_i});
               m_pend = 0;
            end else if (data_i == ESC) begin
               m_pend = 1;
               m_idle = 0;
            end else begin
               mq.push_back({1'b0, data_i});
            end
         end else if (m_pend) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_pend = 0;
               m_to   = 1;
            end
         end
      end
   end

   // TAP-side capture for the streaming test.
   logic [7:0] got[$];
   bit         collect = 0;
   always @(negedge clk) begin
      if (collect && rst_n && read_i && !rx_empty_o) got.push_back(data_o);
   end

   bit to0_seen = 0;
   always @(negedge clk) begin
      if (esc_timeout0_o) to0_seen = 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one symbol and hold it until the DUT pops it.
   task automatic push(input logic [7:0] s);
      rx_empty_i = 1'b0;
      data_i     = s;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (read_o) break;
      end
      chk("push_accept", 32'(read_o), 32'd1);
      step();
      rx_empty_i = 1'b1;
   endtask

   task automatic tap_pop();
      read_i = 1'b1;
      step();
      read_i = 1'b0;
   endtask

   task automatic drain();
      read_i = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rx_empty_o) break;
      end
      chk("drain_empty", 32'(rx_empty_o), 32'd1);
      step();
      read_i = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      // Reset with upstream non-empty: nothing may be popped.
      rx_empty_i = 1'b0;
      data_i     = 8'h33;
      repeat (3) step();
      @(negedge clk);
      chk("rst_read_o",     32'(read_o),     32'd0);
      chk("rst_rx_empty_o", 32'(rx_empty_o), 32'd1);
      chk("rst_level_o",    32'(level_o),    32'd0);
      step();
      rx_empty_i = 1'b1;
      rst_n      = 1'b1;
      step();

      // Plain data, show-ahead head, pops in order.
      push(8'h41);
      push(8'h42);
      @(negedge clk);
      chk("two_level", 32'(level_o),   32'd2);
      chk("two_head",  32'(data_o),    32'h41);
      chk("two_cmd",   32'(command_o), 32'd0);
      step();
      tap_pop();
      @(negedge clk);
      chk("second_head", 32'(data_o), 32'h42);
      step();
      tap_pop();
      @(negedge clk);
      chk("after_pops_empty", 32'(rx_empty_o), 32'd1);
      chk("after_pops_data",  32'(data_o),     32'h00);
      step();

      // ESC ESC -> literal ESC; ESC x -> command x.
      push(8'hB1);
      push(8'hB1);
      @(negedge clk);
      chk("esc_esc_level", 32'(level_o),   32'd1);
      chk("esc_esc_data",  32'(data_o),    32'hB1);
      chk("esc_esc_cmd",   32'(command_o), 32'd0);
      step();
      tap_pop();
      push(8'hB1);
      push(8'h05);
      @(negedge clk);
      chk("esc_cmd_level", 32'(level_o),   32'd1);
      chk("esc_cmd_data",  32'(data_o),    32'h05);
      chk("esc_cmd_cmd",   32'(command_o), 32'd1);
      step();
      tap_pop();

      // Full FIFO stalls upstream, including during a TAP pop.
      for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
      rx_empty_i = 1'b0;
      data_i     = 8'h65;
      repeat (3) begin
         @(negedge clk);
         chk("full_no_pop", 32'(read_o),  32'd0);
         chk("full_level",  32'(level_o), 32'd4);
      end
      step();
      read_i = 1'b1;
      @(negedge clk);
      chk("full_pop_same_cycle", 32'(read_o), 32'd0);
      step();
      read_i = 1'b0;
      @(negedge clk);
      chk("room_read_o", 32'(read_o), 32'd1);
      chk("room_head",   32'(data_o), 32'h62);
      step();
      data_i = 8'h66;
      @(negedge clk);
      chk("fifth_in_level", 32'(level_o), 32'd4);
      chk("sixth_blocked",  32'(read_o),  32'd0);
      step();
      read_i = 1'b1;
      push(8'h66);
      drain();

      // Unanswered ESC expires: pulse in the cycle after the 10th idle edge.
      push(8'hB1);
      k = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (esc_timeout_o) begin
            k = n;
            break;
         end
      end
      chk("timeout_cycle", 32'(k), 32'd11);
      @(negedge clk);
      chk("timeout_single_pulse", 32'(esc_timeout_o), 32'd0);
      step();
      push(8'h07);
      @(negedge clk);
      chk("post_timeout_data", 32'(data_o),    32'h07);
      chk("post_timeout_cmd",  32'(command_o), 32'd0);
      chk("post_timeout_lvl",  32'(level_o),   32'd1);
      step();
      tap_pop();

      // Symbol arriving on the cycle the count would expire wins.
      push(8'hB1);
      repeat (9) step();
      push(8'h05);
      @(negedge clk);
      chk("race_data",  32'(data_o),        32'h05);
      chk("race_cmd",   32'(command_o),     32'd1);
      chk("race_no_to", 32'(esc_timeout_o), 32'd0);
      step();
      tap_pop();

      // TIMEOUT=0 instance keeps the ESC pending indefinitely.
      rx_empty0_i = 1'b0;
      data0_i     = 8'hB1;
      @(negedge clk);
      chk("t0_read_esc", 32'(read0_o), 32'd1);
      step();
      rx_empty0_i = 1'b1;
      repeat (40) step();
      rx_empty0_i = 1'b0;
      data0_i     = 8'h05;
      @(negedge clk);
      chk("t0_read_sym", 32'(read0_o), 32'd1);
      step();
      rx_empty0_i = 1'b1;
      @(negedge clk);
      chk("t0_empty", 32'(rx_empty0_o),  32'd0);
      chk("t0_data",  32'(data0_o),      32'h05);
      chk("t0_cmd",   32'(command0_o),   32'd1);
      chk("t0_level", 32'(level0_o),     32'd1);
      chk("t0_no_to", 32'(to0_seen),     32'd0);
      step();

      // Mid-sequence reset discards the pending ESC.
      push(8'hB1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_clears_dut0", 32'(level0_o), 32'd0);
      step();
      push(8'h07);
      @(negedge clk);
      chk("rst_esc_data",  32'(data_o),    32'h07);
      chk("rst_esc_cmd",   32'(command_o), 32'd0);
      chk("rst_esc_level", 32'(level_o),   32'd1);
      step();
      tap_pop();

      // Full FIFO, TAP reading every cycle, continuous input: 32 symbols.
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      @(negedge clk);
      chk("stream_full", 32'(level_o), 32'd4);
      step();
      collect = 1;
      read_i  = 1'b1;
      for (int i = 4; i < 32; i++) push(8'h10 + 8'(i));
      drain();
      collect = 0;
      chk("stream_count", 32'(got.size()), 32'd32);
      for (int i = 0; i < 32; i++) begin
         chk("stream_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'h10 + 32'(i));
      end

      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
